sprite_scheduler: RTL and testbench

Per-frame sprite scheduler that sequences draw requests into the sprite blit/graphics datapath. Game logic writes sprite entries (position, frame number, enable) into a pending table. A commit latches that table into an active table at the next frame start. During the blanking window the block walks the active table in index order (index 0 drawn first, i.e. backmost) and issues one sprite at a time over a valid/ready handshake.

---
 rtl/sprite_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_sprite_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scheduler.sv
// Per-frame sprite scheduler: double-buffered sprite table (pending/active) walked
// in index order during the blanking window, one sprite per valid/ready transfer.
module sprite_scheduler #(
    parameter int MAX_SPRITES = 16,
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 720,
    parameter int NUM_FRAMES  = 512
) (
    input  logic                             clk_pixel,
    input  logic                             sys_rst_n,
    input  logic                             wr_en,
    input  logic [$clog2(MAX_SPRITES)-1:0]   wr_index,
    input  logic                             wr_enable,
    input  logic [$clog2(WIDTH)-1:0]         wr_x,
    input  logic [$clog2(HEIGHT)-1:0]        wr_y,
    input  logic [$clog2(NUM_FRAMES)-1:0]    wr_frame,
    input  logic                             commit,
    input  logic                             frame_start,
    input  logic                             window_end,
    output logic                             sprite_valid,
    input  logic                             sprite_ready,
    output logic [$clog2(WIDTH)-1:0]         sprite_x,
    output logic [$clog2(HEIGHT)-1:0]        sprite_y,
    output logic [$clog2(NUM_FRAMES)-1:0]    sprite_frame_number,
    output logic [$clog2(MAX_SPRITES)-1:0]   sprite_index,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             overrun,
    output logic [$clog2(MAX_SPRITES):0]     issued_count
);

    localparam int IW = $clog2(MAX_SPRITES);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int CW = IW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          commit_pending;

    logic          pend_en [MAX_SPRITES];
    logic [XW-1:0] pend_x  [MAX_SPRITES];
    logic [YW-1:0] pend_y  [MAX_SPRITES];
    logic [FW-1:0] pend_f  [MAX_SPRITES];

    logic          act_en  [MAX_SPRITES];
    logic [XW-1:0] act_x   [MAX_SPRITES];
    logic [YW-1:0] act_y   [MAX_SPRITES];
    logic [FW-1:0] act_f   [MAX_SPRITES];

    logic start_ok;
    logic do_copy;
    logic last_idx;
    logic xfer;

    always_comb begin
        start_ok = frame_start && (state == S_IDLE);
        do_copy  = start_ok && (commit_pending || commit);
        last_idx = (idx == IW'(MAX_SPRITES - 1));
        xfer     = sprite_valid && sprite_ready;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
                pend_en[i] <= 1'b0;
                pend_x[i]  <= '0;
                pend_y[i]  <= '0;
                pend_f[i]  <= '0;
            end
        end else if (wr_en) begin
            pend_en[wr_index] <= wr_enable;
            pend_x[wr_index]  <= wr_x;
            pend_y[wr_index]  <= wr_y;
            pend_f[wr_index]  <= wr_frame;
        end
    end

    // The copy samples pending before the edge, so a same-cycle write lands in pending only.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            commit_pending <= 1'b0;
            for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
                act_en[i] <= 1'b0;
                act_x[i]  <= '0;
                act_y[i]  <= '0;
                act_f[i]  <= '0;
            end
        end else begin
            if (do_copy) begin
                commit_pending <= 1'b0;
                act_en <= pend_en;
                act_x  <= pend_x;
                act_y  <= pend_y;
                act_f  <= pend_f;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state               <= S_IDLE;
            idx                 <= '0;
            sprite_valid        <= 1'b0;
            sprite_x            <= '0;
            sprite_y            <= '0;
            sprite_frame_number <= '0;
            sprite_index        <= '0;
            frame_done          <= 1'b0;
            overrun             <= 1'b0;
            issued_count        <= '0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        idx          <= '0;
                        issued_count <= '0;
                        overrun      <= 1'b0;
                        state        <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (window_end) begin
                        overrun    <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end else if (act_en[idx]) begin
                        sprite_x            <= act_x[idx];
                        sprite_y            <= act_y[idx];
                        sprite_frame_number <= act_f[idx];
                        sprite_index        <= idx;
                        sprite_valid        <= 1'b1;
                        state               <= S_ISSUE;
                    end else if (last_idx) begin
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end

                S_ISSUE: begin
                    // A transfer completing alongside window_end is still counted.
                    if (xfer) begin
                        issued_count <= issued_count + CW'(1);
                        sprite_valid <= 1'b0;
                    end
                    if (window_end) begin
                        sprite_valid <= 1'b0;
                        overrun      <= 1'b1;
                        frame_done   <= 1'b1;
                        state        <= S_DONE;
                    end else if (xfer) begin
                        if (last_idx) begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_SCAN;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler: expected transfers are queued as stimulus
// is driven and popped as the DUT completes each valid/ready handshake.
module tb_sprite_scheduler;

    localparam int MS = 16;
    localparam int IW = 4;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int FW = 9;
    localparam int PW = IW + XW + YW + FW;

    logic          clk_pixel = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_index = '0;
    logic          wr_enable = 1'b0;
    logic [XW-1:0] wr_x = '0;
    logic [YW-1:0] wr_y = '0;
    logic [FW-1:0] wr_frame = '0;
    logic          commit = 1'b0;
    logic          frame_start = 1'b0;
    logic          window_end = 1'b0;
    logic          sprite_valid;
    logic          sprite_ready = 1'b0;
    logic [XW-1:0] sprite_x;
    logic [YW-1:0] sprite_y;
    logic [FW-1:0] sprite_frame_number;
    logic [IW-1:0] sprite_index;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    logic [IW:0]   issued_count;

    sprite_scheduler #(
        .MAX_SPRITES (16),
        .WIDTH       (1280),
        .HEIGHT      (720),
        .NUM_FRAMES  (512)
    ) dut (
        .clk_pixel           (clk_pixel),
        .sys_rst_n           (sys_rst_n),
        .wr_en               (wr_en),
        .wr_index            (wr_index),
        .wr_enable           (wr_enable),
        .wr_x                (wr_x),
        .wr_y                (wr_y),
        .wr_frame            (wr_frame),
        .commit              (commit),
        .frame_start         (frame_start),
        .window_end          (window_end),
        .sprite_valid        (sprite_valid),
        .sprite_ready        (sprite_ready),
        .sprite_x            (sprite_x),
        .sprite_y            (sprite_y),
        .sprite_frame_number (sprite_frame_number),
        .sprite_index        (sprite_index),
        .busy                (busy),
        .frame_done          (frame_done),
        .overrun             (overrun),
        .issued_count        (issued_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_cnt = 0;
    logic [PW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [PW-1:0] pack(input int i, input int x, input int y, input int f);
        return {IW'(i), XW'(x), YW'(y), FW'(f)};
    endfunction

    // Handshake is sampled mid-cycle; it completes at the following rising edge.
    always @(negedge clk_pixel) begin
        if (sys_rst_n && sprite_valid && sprite_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", 64'(sprite_index), 64'hFFFF);
            end else begin
                check("xfer_fields", 64'({sprite_index, sprite_x, sprite_y, sprite_frame_number}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic write_entry(input int i, input logic en, input int x, input int y, input int f);
        wr_en = 1'b1; wr_index = IW'(i); wr_enable = en;
        wr_x = XW'(x); wr_y = YW'(y); wr_frame = FW'(f);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1; tick(); commit = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 300; k++) begin
            if (frame_done) break;
            tick();
        end
        check({tag, "_frame_done"}, 64'(frame_done), 64'd1);
        tick();
        check({tag, "_done_one_cycle"}, 64'(frame_done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // All 16 entries as written by the full-table test; entry 2 optionally replaced.
    task automatic push_all(input bit new2);
        for (int i = 0; i < MS; i++) begin
            if (new2 && i == 2) exp_q.push_back(pack(2, 777, 700, 5));
            else exp_q.push_back(pack(i, i * 10, i, i + 100));
        end
    endtask

    initial begin
        tick(); tick();
        check("rst_valid", 64'(sprite_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(issued_count), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        sys_rst_n = 1'b1;
        tick();

        // Empty table: scan runs, nothing issued.
        sprite_ready = 1'b1;
        pulse_commit();
        pulse_start();
        check("empty_busy", 64'(busy), 64'd1);
        wait_done("empty");
        check("empty_count", 64'(issued_count), 64'd0);
        check("empty_xfers", 64'(xfer_cnt), 64'd0);

        // Two sparse entries, boundary field values.
        write_entry(0, 1'b1, 100, 50, 3);
        write_entry(5, 1'b1, 640, 360, 511);
        pulse_commit();
        exp_q.push_back(pack(0, 100, 50, 3));
        exp_q.push_back(pack(5, 640, 360, 511));
        pulse_start();
        check("lat_t1_valid", 64'(sprite_valid), 64'd0);
        tick();
        check("lat_t2_valid", 64'(sprite_valid), 64'd1);
        wait_done("two");
        check("two_count", 64'(issued_count), 64'd2);
        check("two_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure, no commit: the active table is re-issued.
        sprite_ready = 1'b0;
        exp_q.push_back(pack(0, 100, 50, 3));
        exp_q.push_back(pack(5, 640, 360, 511));
        pulse_start();
        tick();
        for (int k = 0; k < 7; k++) begin
            check("hold_stable", 64'({sprite_valid, sprite_index, sprite_x, sprite_y, sprite_frame_number}),
                  64'({1'b1, pack(0, 100, 50, 3)}));
            tick();
        end
        check("hold_count", 64'(issued_count), 64'd0);
        sprite_ready = 1'b1;
        wait_done("hold");
        check("hold_final_count", 64'(issued_count), 64'd2);

        // Full table, window closed after four transfers.
        for (int i = 0; i < MS; i++) write_entry(i, 1'b1, i * 10, i, i + 100);
        pulse_commit();
        for (int i = 0; i < 4; i++) exp_q.push_back(pack(i, i * 10, i, i + 100));
        xfer_cnt = 0;
        pulse_start();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_pixel);
            if (xfer_cnt == 4) break;
        end
        check("we_reached_4", 64'(xfer_cnt), 64'd4);
        window_end = 1'b1;
        tick();
        window_end = 1'b0;
        check("we_valid_drop", 64'(sprite_valid), 64'd0);
        wait_done("we");
        check("we_count", 64'(issued_count), 64'd4);
        check("we_overrun", 64'(overrun), 64'd1);

        // Next frame clears overrun; a frame_start while busy sets it again.
        push_all(1'b0);
        pulse_start();
        check("clr_overrun", 64'(overrun), 64'd0);
        tick(); tick(); tick();
        pulse_start();
        check("busy_start_overrun", 64'(overrun), 64'd1);
        wait_done("full");
        check("full_count", 64'(issued_count), 64'd16);

        // Same-cycle write during the copy stays pending only.
        pulse_commit();
        push_all(1'b0);
        frame_start = 1'b1;
        wr_en = 1'b1; wr_index = 4'd2; wr_enable = 1'b1;
        wr_x = 11'd777; wr_y = 10'd700; wr_frame = 9'd5;
        tick();
        frame_start = 1'b0; wr_en = 1'b0;
        wait_done("race_old");
        check("race_old_count", 64'(issued_count), 64'd16);
        pulse_commit();
        push_all(1'b1);
        pulse_start();
        wait_done("race_new");
        check("race_new_count", 64'(issued_count), 64'd16);
        check("race_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-issue, then a frame with no commit issues nothing.
        sprite_ready = 1'b0;
        pulse_start();
        tick();
        check("pre_rst_valid", 64'(sprite_valid), 64'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(sprite_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        sprite_ready = 1'b1;
        xfer_cnt = 0;
        pulse_start();
        wait_done("post_rst");
        check("post_rst_count", 64'(issued_count), 64'd0);
        check("post_rst_xfers", 64'(xfer_cnt), 64'd0);
        check("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
